// File: rtl/ofm_csum_calc.sv
// Transmit checksum-offload engine: forwards one frame per ctrl entry into the
// outbound buffer and emits its 16-bit ones-complement checksum entry.
module ofm_csum_calc (
    input  logic        mm2s_clk,
    input  logic        mm2s_reset,
    input  logic [63:0] ctrl_fifo_rdata,
    input  logic        ctrl_fifo_empty,
    output logic        ctrl_fifo_rden,
    input  logic [72:0] data_fifo_rdata,
    input  logic        data_fifo_empty,
    output logic        data_fifo_rden,
    output logic [72:0] out_fifo_wdata,
    output logic        out_fifo_wren,
    input  logic        out_fifo_afull,
    output logic [32:0] csum_fifo_wdata,
    output logic        csum_fifo_wren,
    input  logic        csum_fifo_afull,
    output logic [3:0]  ofm_csum_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CTRL  = 3'd1,
        S_DATA  = 3'd2,
        S_FOLD1 = 3'd3,
        S_FOLD2 = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] begin_q, begin_d;
    logic [15:0] insert_q, insert_d;
    logic [1:0]  cntrl_q, cntrl_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        out_afull_q, csum_afull_q;
    logic        out_wren_q, out_wren_d;
    logic [72:0] out_wdata_q, out_wdata_d;
    logic        csum_wren_q, csum_wren_d;
    logic [32:0] csum_wdata_q, csum_wdata_d;

    logic [7:0][15:0] lane_idx_s;
    logic [7:0][7:0]  lane_byte_s;
    logic [31:0]      word_sum_s;
    logic [31:0]      fold_s;
    logic [15:0]      res_s;
    logic             ctrl_rden_s, data_rden_s;
    logic             unused_ok_s;

    assign unused_ok_s = ^{ctrl_fifo_rdata[63:50], wcnt_q[15:13]};

    // Mask each lane by keep and by its absolute byte index against cs_begin.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lane_idx_s[k] = {wcnt_q[12:0], 3'b000} + 16'(k);
            if (data_fifo_rdata[64 + k] && (lane_idx_s[k] >= begin_q)) begin
                lane_byte_s[k] = data_fifo_rdata[8*k +: 8];
            end else begin
                lane_byte_s[k] = 8'h00;
            end
        end
    end

    // Network order: even lane is the high byte of each 16-bit term.
    always_comb begin
        word_sum_s = 32'h0000_0000;
        for (int j = 0; j < 4; j++) begin
            word_sum_s = word_sum_s + {16'h0000, lane_byte_s[2*j], lane_byte_s[2*j+1]};
        end
    end

    assign fold_s = {16'h0000, acc_q[31:16]} + {16'h0000, acc_q[15:0]};
    assign res_s  = ~fold_s[15:0];

    // Next-state, datapath updates and FIFO strobes.
    always_comb begin
        state_d      = state_q;
        begin_d      = begin_q;
        insert_d     = insert_q;
        cntrl_d      = cntrl_q;
        acc_d        = acc_q;
        wcnt_d       = wcnt_q;
        out_wren_d   = 1'b0;
        out_wdata_d  = out_wdata_q;
        csum_wren_d  = 1'b0;
        csum_wdata_d = csum_wdata_q;
        ctrl_rden_s  = 1'b0;
        data_rden_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!ctrl_fifo_empty && !csum_afull_q) begin
                    state_d = S_CTRL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CTRL: begin
                ctrl_rden_s = 1'b1;
                begin_d     = ctrl_fifo_rdata[15:0];
                insert_d    = ctrl_fifo_rdata[31:16];
                cntrl_d     = ctrl_fifo_rdata[49:48];
                acc_d       = {16'h0000, ctrl_fifo_rdata[47:32]};
                wcnt_d      = 16'h0000;
                state_d     = S_DATA;
            end
            S_DATA: begin
                data_rden_s = !data_fifo_empty && !out_afull_q;
                if (data_rden_s) begin
                    acc_d       = acc_q + word_sum_s;
                    wcnt_d      = wcnt_q + 16'h0001;
                    out_wren_d  = 1'b1;
                    out_wdata_d = data_fifo_rdata;
                    if (data_fifo_rdata[72]) begin
                        state_d = S_FOLD1;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_FOLD1: begin
                acc_d   = fold_s;
                state_d = S_FOLD2;
            end
            S_FOLD2: begin
                acc_d       = fold_s;
                csum_wren_d = 1'b1;
                case (cntrl_q)
                    2'b00:   csum_wdata_d = {1'b0, insert_q, 16'h0000};
                    2'b10:   csum_wdata_d = {1'b1, insert_q, (res_s == 16'h0000) ? 16'hFFFF : res_s};
                    default: csum_wdata_d = {1'b1, insert_q, res_s};
                endcase
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge mm2s_clk or posedge mm2s_reset) begin
        if (mm2s_reset) begin
            state_q      <= S_IDLE;
            begin_q      <= 16'h0000;
            insert_q     <= 16'h0000;
            cntrl_q      <= 2'b00;
            acc_q        <= 32'h0000_0000;
            wcnt_q       <= 16'h0000;
            out_afull_q  <= 1'b0;
            csum_afull_q <= 1'b0;
            out_wren_q   <= 1'b0;
            out_wdata_q  <= 73'h0;
            csum_wren_q  <= 1'b0;
            csum_wdata_q <= 33'h0;
        end else begin
            state_q      <= state_d;
            begin_q      <= begin_d;
            insert_q     <= insert_d;
            cntrl_q      <= cntrl_d;
            acc_q        <= acc_d;
            wcnt_q       <= wcnt_d;
            out_afull_q  <= out_fifo_afull;
            csum_afull_q <= csum_fifo_afull;
            out_wren_q   <= out_wren_d;
            out_wdata_q  <= out_wdata_d;
            csum_wren_q  <= csum_wren_d;
            csum_wdata_q <= csum_wdata_d;
        end
    end

    assign ctrl_fifo_rden  = ctrl_rden_s;
    assign data_fifo_rden  = data_rden_s;
    assign out_fifo_wren   = out_wren_q;
    assign out_fifo_wdata  = out_wdata_q;
    assign csum_fifo_wren  = csum_wren_q;
    assign csum_fifo_wdata = csum_wdata_q;
    assign ofm_csum_dbg    = {1'b0, state_q};

endmodule

// File: doc/ofm_csum_calc.md
# ofm_csum_calc

Transmit checksum-offload engine downstream of the `ofm_in_fsm` control/data ingest stage. It pops one per-frame control entry from the ctrl FIFO and the matching frame from the data FIFO. The frame words are forwarded unchanged into the outbound frame buffer FIFO. While forwarding, the block computes the 16-bit ones-complement checksum of the frame bytes from the checksum start offset to the end, seeded with the init value, and emits one checksum-result entry per frame for the checksum-insert stage.

## Interface
- No parameters.
- `mm2s_clk`  in  1  sole clock.
- `mm2s_reset`  in  1  reset, asynchronous, active-high.
- `ctrl_fifo_rdata`  in  64  FWFT head entry: [15:0] cs_begin, [31:16] cs_insert, [47:32] cs_init, [49:48] cs_cntrl, [63:50] ignored.
- `ctrl_fifo_empty`  in  1  ctrl FIFO empty.
- `ctrl_fifo_rden`  out  1  pop ctrl entry.
- `data_fifo_rdata`  in  73  FWFT head word: [63:0] data, [71:64] keep, [72] last.
- `data_fifo_empty`  in  1  data FIFO empty.
- `data_fifo_rden`  out  1  pop data word.
- `out_fifo_wdata`  out  73  forwarded word, same layout as `data_fifo_rdata`.
- `out_fifo_wren`  out  1  write strobe.
- `out_fifo_afull`  in  1  almost full; must assert with at least 3 free entries remaining.
- `csum_fifo_wdata`  out  33  result entry: [15:0] checksum, [31:16] cs_insert, [32] enable.
- `csum_fifo_wren`  out  1  write strobe.
- `csum_fifo_afull`  in  1  almost full; must assert with at least 2 free entries remaining.
- `ofm_csum_dbg`  out  4  {1'b0, state[2:0]}.

## Operation
- Upstream writes the ctrl entry only after the frame's last data word. A non-empty ctrl FIFO therefore guarantees that the whole frame is resident in the data FIFO.
- States:
  - IDLE: go to CTRL when ctrl not empty and registered `csum_fifo_afull` is 0.
  - CTRL: one cycle. Pulse `ctrl_fifo_rden`, latch begin, insert, init and cntrl. Set acc = {16'h0, init}. Set wcnt = 0. Go to DATA.
  - DATA: assert `data_fifo_rden` = !data_fifo_empty && !out_afull_reg. On each pop, accumulate, increment wcnt, and go to FOLD1 when the popped word has last = 1.
  - FOLD1: acc = acc[31:16] + acc[15:0].
  - FOLD2: same fold again. Compute res = ~acc[15:0]. Write the csum entry. Go to IDLE.
- Byte index of lane k in word wcnt is 8*wcnt + k, 16-bit, where lane k is data[8k+7:8k].
- A byte contributes only if keep[k] = 1 and its index ≥ cs_begin.
- Contributing bytes are treated as network order:
  - even lanes (k even) form the high byte of a 16-bit term;
  - odd lanes form the low byte.
  - Four 16-bit terms are added to acc per word in a 32-bit accumulator. Carries are preserved until the folds.
- cs_cntrl:
  - 00: disabled. Frame is still forwarded, entry bit32 = 0, checksum field = 0.
  - 01 or 11: TCP mode, enable = 1, checksum = res.
  - 10: UDP mode, enable = 1, checksum = res, except that 16'h0000 is replaced by 16'hFFFF.
- cs_insert is copied through unchanged.
- Frames are at most 9600 bytes; wcnt never wraps.

## Timing
- Reset values: all outputs are 0, state = IDLE, acc = 0, afull registers = 0.
- `mm2s_reset` mid-frame immediately returns the block to IDLE and drops the partial frame state. Surrounding FIFOs share the same reset.
- Both afull inputs are registered once before use.
- `out_fifo_wren` and `out_fifo_wdata` are registered: one cycle after the corresponding `data_fifo_rden`, with the data captured at pop.
- `ctrl_fifo_rden` and `data_fifo_rden` are combinational from state and registered flags, at most one pop each per cycle.
- `csum_fifo_wren` is a one-cycle pulse in FOLD2, registered, so it appears in the cycle after FOLD2.
- Latency: last data pop to `csum_fifo_wren` is 3 cycles. Minimum inter-frame gap is IDLE, CTRL, FOLD1, FOLD2, i.e. 4 cycles of overhead per frame.
- Data FIFO empty in DATA (upstream fault): stall with no pop and no state change.
- A simultaneous non-empty ctrl FIFO and set `csum_fifo_afull` holds the block in IDLE.

## Test plan
- cs_cntrl = 00, 3-word frame of keep FF/FF/0F → out FIFO receives 3 identical words in order; one csum entry with [32] = 0, [15:0] = 0.
- TCP, begin = 0, init = 0, one word bytes 01..08 (lane 0 = 01), keep FF, last → acc 0x1014; entry checksum 0xEFEB, enable 1, insert echoed (e.g. 0x0032).
- begin = 6, init = 0x1234, word 0 bytes 01..08, word 1 keep 0x03 bytes AA, BB, last → terms 0x0708 + 0xAABB + 0x1234 = 0xC3F7; checksum 0x3C08.
- Carry fold: init = 0xFFFF, one word keep 0x03 bytes 00, 01 → 0x10000 folds to 0x0001; checksum 0xFFFE.
- Zero result: init = 0, keep 0x03 bytes FF, FF → res 0x0000. Mode 01 outputs 0x0000; mode 10 outputs 0xFFFF.
- Backpressure and reset:
  - Toggle `out_fifo_afull` every 3 cycles over a 20-word frame → exactly 20 writes, no duplicates, and the correct checksum.
  - Assert `mm2s_reset` after word 5 of a frame → all outputs 0 next cycle and state IDLE.
